// File: rtl/bidir_strobe_ctrl_if.sv
// Requester-side handshake and status bundle for bidir_strobe_ctrl.
// The master side belongs to the requesters. The slave side belongs to the controller.
interface bidir_strobe_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             req_a;
  logic [LEN_W-1:0] len_a;
  logic             gnt_a;
  logic             done_a;
  logic             req_b;
  logic [LEN_W-1:0] len_b;
  logic             gnt_b;
  logic             done_b;
  logic             busy;
  logic             os_oe;
  logic             rx_strobe;

  modport master (
    output req_a, len_a, req_b, len_b,
    input  gnt_a, done_a, gnt_b, done_b, busy, os_oe, rx_strobe
  );

  modport slave (
    input  req_a, len_a, req_b, len_b,
    output gnt_a, done_a, gnt_b, done_b, busy, os_oe, rx_strobe
  );
endinterface

// File: rtl/bidir_strobe_ctrl.sv
// Round-robin sequencer for a shared bidirectional strobe pad: turnaround, preamble, burst, postamble.
// Define STROBE_CTRL_DIFF_EN to drive pad_io_l as the complement of pad_io_h. Otherwise pad_io_l stays high-Z.
module bidir_strobe_ctrl #(
  parameter int TURN  = 2,
  parameter int PRE   = 1,
  parameter int POST  = 1,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bidir_strobe_ctrl_if.slave   bus,
  inout  wire                  pad_io_h,
  inout  wire                  pad_io_l
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_PRE,
    S_BURST,
    S_POST
  } state_t;

  localparam int PW = 8;
  // A back-to-back grant gets at least one turnaround cycle, even when TURN is 0.
  localparam logic [PW-1:0] TURN_LD = PW'((TURN > 1) ? TURN - 1 : 0);
  localparam logic [PW-1:0] PRE_LD  = PW'(PRE - 1);
  localparam logic [PW-1:0] POST_LD = PW'(POST - 1);

  state_t           state;
  logic [PW-1:0]    pcnt;
  logic [LEN_W:0]   bcnt;
  logic [LEN_W-1:0] len_q;
  logic             owner_b;
  logic             last_b;
  logic             strobe;
  logic             os_oe;
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic             rx_q;

  logic any_req;
  logic tie;
  logic pick_b;

  assign any_req = bus.req_a | bus.req_b;
  assign tie     = bus.req_a & bus.req_b;
  assign pick_b  = bus.req_b & (~bus.req_a | ~last_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pcnt    <= '0;
      bcnt    <= '0;
      len_q   <= '0;
      owner_b <= 1'b0;
      last_b  <= 1'b1;
      strobe  <= 1'b0;
      os_oe   <= 1'b0;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
      rx_q    <= 1'b0;
    end else begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      rx_q   <= os_oe ? 1'b0 : pad_io_h;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_b <= pick_b;
            len_q   <= pick_b ? bus.len_b : bus.len_a;
            gnt_a   <= ~pick_b;
            gnt_b   <= pick_b;
            if (tie) last_b <= pick_b;
            if (TURN > 0) begin
              state <= S_TURN;
              pcnt  <= TURN_LD;
            end else begin
              state  <= S_PRE;
              pcnt   <= PRE_LD;
              os_oe  <= 1'b1;
              strobe <= 1'b0;
            end
          end
        end
        S_TURN: begin
          if (pcnt == '0) begin
            state  <= S_PRE;
            pcnt   <= PRE_LD;
            os_oe  <= 1'b1;
            strobe <= 1'b0;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        S_PRE: begin
          if (pcnt != '0) begin
            pcnt <= pcnt - 1'b1;
          end else if (len_q != '0) begin
            state  <= S_BURST;
            bcnt   <= {len_q, 1'b0} - (LEN_W+1)'(1);
            strobe <= 1'b1;
          end else begin
            state  <= S_POST;
            pcnt   <= POST_LD;
            strobe <= 1'b0;
          end
        end
        S_BURST: begin
          if (bcnt == '0) begin
            state  <= S_POST;
            pcnt   <= POST_LD;
            strobe <= 1'b0;
          end else begin
            bcnt   <= bcnt - 1'b1;
            strobe <= ~strobe;
          end
        end
        S_POST: begin
          if (pcnt != '0) begin
            pcnt <= pcnt - 1'b1;
          end else begin
            done_a <= ~owner_b;
            done_b <= owner_b;
            os_oe  <= 1'b0;
            strobe <= 1'b0;
            if (any_req) begin
              owner_b <= pick_b;
              len_q   <= pick_b ? bus.len_b : bus.len_a;
              gnt_a   <= ~pick_b;
              gnt_b   <= pick_b;
              if (tie) last_b <= pick_b;
              state   <= S_TURN;
              pcnt    <= TURN_LD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_a     = gnt_a;
  assign bus.gnt_b     = gnt_b;
  assign bus.done_a    = done_a;
  assign bus.done_b    = done_b;
  assign bus.busy      = (state != S_IDLE);
  assign bus.os_oe     = os_oe;
  assign bus.rx_strobe = rx_q;

  assign pad_io_h = os_oe ? strobe : 1'bz;
`ifdef STROBE_CTRL_DIFF_EN
  assign pad_io_l = os_oe ? ~strobe : 1'bz;
`else
  assign pad_io_l = 1'bz;
`endif

endmodule

// File: tb/tb_bidir_strobe_ctrl.sv
// Directed bench for bidir_strobe_ctrl using default parameters. Outputs are sampled on the falling clock edge.
// Build with or without STROBE_CTRL_DIFF_EN. The pad_io_l checks change to match the build.
module tb_bidir_strobe_ctrl;

  logic clk;
  logic rst_n;
  wire  pad_io_h;
  wire  pad_io_l;
  logic h_drv;
  logic h_val;
  logic l_drv;
  int   checks;
  int   fails;

  bidir_strobe_ctrl_if #(.LEN_W(4)) bus ();

  bidir_strobe_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pad_io_h (pad_io_h),
    .pad_io_l (pad_io_l)
  );

  // In the single-ended build the bench holds pad_io_l low, so any driving by the DUT shows up as contention.
  assign pad_io_h = h_drv ? h_val : 1'bz;
  assign pad_io_l = l_drv ? 1'b0 : 1'bz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    tick();
    tick();
    obs = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.os_oe, bus.rx_strobe};
    checks++;
    if (obs !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 7'b0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_a();
    logic exp_h [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] obs;
    bus.req_a = 1'b1;
    bus.len_a = 4'd2;
    tick();
    obs = {bus.gnt_a, bus.gnt_b, bus.busy, bus.os_oe};
    checks++;
    if (obs !== 4'b1010) begin
      fails++;
      $display("[TB] FAIL single_grant: got %b expected %b", obs, 4'b1010);
    end
    bus.req_a = 1'b0;
    tick();
    obs = {bus.gnt_a, bus.gnt_b, bus.busy, bus.os_oe};
    checks++;
    if (obs !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL single_turn: got %b expected %b", obs, 4'b0010);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({bus.os_oe, pad_io_h, bus.done_a} !== {1'b1, exp_h[i], 1'b0}) begin
        fails++;
        $display("[TB] FAIL single_drive[%0d]: got oe/pad/done %b%b%b expected %b%b0",
                 i, bus.os_oe, pad_io_h, bus.done_a, 1'b1, exp_h[i]);
      end
      if (i > 0) begin
        checks++;
        if (bus.rx_strobe !== 1'b0) begin
          fails++;
          $display("[TB] FAIL single_rx_driven[%0d]: got %b expected 0", i, bus.rx_strobe);
        end
      end
    end
    tick();
    obs = {bus.done_a, bus.done_b, bus.busy, bus.os_oe};
    checks++;
    if (obs !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL single_done: got %b expected %b", obs, 4'b1000);
    end
    checks++;
    if (bus.rx_strobe !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_rx_after: got %b expected 0", bus.rx_strobe);
    end
    tick();
    checks++;
    if (bus.done_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_done_pulse: got %b expected 0", bus.done_a);
    end
  endtask

  task automatic test_alternation();
    logic [1:0] own [3] = '{2'b10, 2'b01, 2'b10};
    logic [1:0] exp_gnt;
    logic [4:0] mid;
    logic [4:0] obs;
    bus.len_a = 4'd1;
    bus.len_b = 4'd1;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    tick();
    checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL alt_first_grant: got %b expected 10", {bus.gnt_a, bus.gnt_b});
    end
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        mid = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy};
        checks++;
        if (mid !== 5'b00001) begin
          fails++;
          $display("[TB] FAIL alt_mid[%0d.%0d]: got %b expected 00001", r, k, mid);
        end
      end
      tick();
      exp_gnt = (r < 2) ? own[r+1] : 2'b00;
      obs = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy};
      checks++;
      if (obs !== {exp_gnt, own[r], (r < 2) ? 1'b1 : 1'b0}) begin
        fails++;
        $display("[TB] FAIL alt_handover[%0d]: got %b expected %b",
                 r, obs, {exp_gnt, own[r], (r < 2) ? 1'b1 : 1'b0});
      end
      if (r == 1) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end
    end
  endtask

  task automatic test_zero_len();
    logic [1:0] obs;
    bus.len_b = 4'd0;
    bus.req_b = 1'b1;
    tick();
    checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL zero_grant: got %b expected 01", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_b = 1'b0;
    tick();
    checks++;
    if (bus.os_oe !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_turn: got %b expected 0", bus.os_oe);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {bus.os_oe, pad_io_h};
      checks++;
      if (obs !== 2'b10) begin
        fails++;
        $display("[TB] FAIL zero_drive[%0d]: got %b expected 10", i, obs);
      end
    end
    tick();
    checks++;
    if ({bus.os_oe, bus.done_a, bus.done_b} !== 3'b001) begin
      fails++;
      $display("[TB] FAIL zero_done: got %b expected 001", {bus.os_oe, bus.done_a, bus.done_b});
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [5:0] obs;
    bus.len_a = 4'd3;
    bus.req_a = 1'b1;
    tick();
    bus.req_a = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({bus.os_oe, pad_io_h} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL abort_in_burst: got %b expected 11", {bus.os_oe, pad_io_h});
    end
    rst_n = 1'b0;
    tick();
    obs = {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy, bus.os_oe};
    checks++;
    if (obs !== 6'b0) begin
      fails++;
      $display("[TB] FAIL abort_outputs: got %b expected 000000", obs);
    end
    h_drv = 1'b1;
    h_val = 1'b1;
    #1;
    checks++;
    if (pad_io_h !== 1'b1) begin
      fails++;
      $display("[TB] FAIL abort_pad_released: got %b expected 1", pad_io_h);
    end
    h_drv = 1'b0;
    bus.len_a = 4'd0;
    bus.len_b = 4'd0;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.done_a, bus.done_b} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL abort_held: got %b expected 000", {bus.busy, bus.done_a, bus.done_b});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL abort_tie_grant: got %b expected 10", {bus.gnt_a, bus.gnt_b});
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    for (int i = 0; i < 20 && bus.busy === 1'b1; i++) tick();
    checks++;
    if ({bus.busy, bus.done_a, bus.done_b} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL abort_followup_done: got %b expected 010", {bus.busy, bus.done_a, bus.done_b});
    end
    tick();
  endtask

  task automatic test_rx_idle();
    logic v [3] = '{1'b1, 1'b0, 1'b1};
    h_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h_val = v[i];
      tick();
      checks++;
      if (bus.rx_strobe !== v[i]) begin
        fails++;
        $display("[TB] FAIL rx_idle[%0d]: got %b expected %b", i, bus.rx_strobe, v[i]);
      end
    end
    h_drv = 1'b0;
    tick();
  endtask

  task automatic test_pad_l();
    logic exp_oe [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_h  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.len_a = 4'd1;
    bus.req_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.req_a = 1'b0;
      checks++;
      if (bus.os_oe !== exp_oe[i]) begin
        fails++;
        $display("[TB] FAIL padl_oe[%0d]: got %b expected %b", i, bus.os_oe, exp_oe[i]);
      end
      if (exp_oe[i]) begin
        checks++;
        if (pad_io_h !== exp_h[i]) begin
          fails++;
          $display("[TB] FAIL padl_h[%0d]: got %b expected %b", i, pad_io_h, exp_h[i]);
        end
`ifdef STROBE_CTRL_DIFF_EN
        checks++;
        if (pad_io_l !== ~exp_h[i]) begin
          fails++;
          $display("[TB] FAIL padl_diff[%0d]: got %b expected %b", i, pad_io_l, ~exp_h[i]);
        end
`endif
      end
`ifndef STROBE_CTRL_DIFF_EN
      checks++;
      if (pad_io_l !== 1'b0) begin
        fails++;
        $display("[TB] FAIL padl_undriven[%0d]: got %b expected 0", i, pad_io_l);
      end
`endif
    end
    checks++;
    if (bus.done_a !== 1'b1) begin
      fails++;
      $display("[TB] FAIL padl_done: got %b expected 1", bus.done_a);
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    h_drv     = 1'b0;
    h_val     = 1'b0;
`ifdef STROBE_CTRL_DIFF_EN
    l_drv     = 1'b0;
`else
    l_drv     = 1'b1;
`endif
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.len_a = '0;
    bus.len_b = '0;
    @(negedge clk);
    test_reset();
    test_single_a();
    test_alternation();
    test_zero_len();
    test_reset_mid_burst();
    test_rx_idle();
    test_pad_l();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
